fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if2id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: data width, reset
// defaults, FSM state encoding and the PC increment helper.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // StFetch: request outstanding. StHold: acked word parked in the hold buffer.
    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StHold  = 1'b1
    } fetch_state_e;

    // Sequential PC; wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if2id_reg.sv
// IF/ID pipeline register. Priority: flush > freeze > load > bubble.
// A bubble or flush replaces the instruction with NOP and keeps Next_Address.
module if2id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_freeze,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_next_addr,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_next_addr,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_next_addr;
    logic            r_valid;

    // Pipeline register update with flush/freeze/load priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr     <= NOP_INSTR;
            r_next_addr <= '0;
            r_valid     <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!i_freeze) begin
            if (i_load) begin
                r_instr     <= i_instr;
                r_next_addr <= i_next_addr;
                r_valid     <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr     = r_instr;
    assign o_next_addr = r_next_addr;
    assign o_valid     = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, one-word hold buffer and the
// IF/ID register. Optional performance counters with FETCH_STAGE_PERF_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            freeze,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] Branch_Address,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] Next_Address,
`ifdef FETCH_STAGE_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic            if_valid
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_buf_instr;
    logic [XLEN-1:0] r_buf_next;
    logic            r_pend;
    logic [XLEN-1:0] r_pend_addr;

    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_buf_instr_nxt;
    logic [XLEN-1:0] w_buf_next_nxt;
    logic            w_pend_nxt;
    logic [XLEN-1:0] w_pend_addr_nxt;
    logic            w_load;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_load_next;

    assign w_pc_plus4 = pc_incr(r_pc);

    // The PC must not move while a request is outstanding, so a redirect seen
    // before the ack is parked in r_pend/r_pend_addr and applied on the ack.
    assign imem_req  = (r_state == StFetch) && !rst;
    assign imem_addr = r_pc;

    // State register, PC, hold buffer and pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StFetch;
            r_pc        <= RESET_PC;
            r_buf_instr <= '0;
            r_buf_next  <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_next  <= w_buf_next_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

    // Next-state, PC selection and IF/ID load request.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_next_nxt  = r_buf_next;
        w_pend_nxt      = r_pend;
        w_pend_addr_nxt = r_pend_addr;
        w_load          = 1'b0;
        w_load_instr    = imem_rdata;
        w_load_next     = w_pc_plus4;

        case (r_state)
            StFetch: begin
                if (imem_ack) begin
                    if (r_pend || PCSrc) begin
                        // Wrong-path word: drop it; a fresh redirect beats the parked one.
                        w_pc_nxt   = PCSrc ? Branch_Address : r_pend_addr;
                        w_pend_nxt = 1'b0;
                    end else if (!freeze && PCWrite) begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_plus4;
                    end else begin
                        w_buf_instr_nxt = imem_rdata;
                        w_buf_next_nxt  = w_pc_plus4;
                        w_state_nxt     = StHold;
                    end
                end else if (PCSrc) begin
                    w_pend_nxt      = 1'b1;
                    w_pend_addr_nxt = Branch_Address;
                end
            end
            StHold: begin
                if (PCSrc) begin
                    w_pc_nxt    = Branch_Address;
                    w_state_nxt = StFetch;
                end else if (!freeze && PCWrite) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf_instr;
                    w_load_next  = r_buf_next;
                    w_pc_nxt     = w_pc_plus4;
                    w_state_nxt  = StFetch;
                end
            end
            default: begin
                w_state_nxt = StFetch;
            end
        endcase
    end

    if2id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if2id (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_freeze    (freeze),
        .i_flush     (flush),
        .i_instr     (w_load_instr),
        .i_next_addr (w_load_next),
        .o_instr     (Instruction),
        .o_next_addr (Next_Address),
        .o_valid     (if_valid)
    );

`ifdef FETCH_STAGE_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_fetch_evt;
    logic        w_stall_evt;

    // A valid word enters IF/ID only when loaded and not flushed.
    assign w_fetch_evt = w_load && !flush;
    assign w_stall_evt = (r_state == StHold) || ((r_state == StFetch) && !imem_ack);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch_evt) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_stall_evt) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        freeze;
    logic        PCSrc;
    logic [31:0] Branch_Address;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] Next_Address;
    logic        if_valid;
`ifdef FETCH_STAGE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .freeze         (freeze),
        .PCSrc          (PCSrc),
        .Branch_Address (Branch_Address),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .Next_Address   (Next_Address),
`ifdef FETCH_STAGE_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] nxt, input logic vld);
        check({tag, ".instr"}, Instruction, instr);
        check({tag, ".next"}, Next_Address, nxt);
        check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, vld});
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic drive(input logic ack, input logic [31:0] rd, input logic frz,
                         input logic pcw, input logic src, input logic [31:0] ba,
                         input logic fl);
        imem_ack       = ack;
        imem_rdata     = rd;
        freeze         = frz;
        PCWrite        = pcw;
        PCSrc          = src;
        Branch_Address = ba;
        flush          = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk_ifid("rst", NOP, 32'h0, 1'b0);
        chk_fetch("rst", 1'b0, 32'h0);

        // Ack during reset is ignored.
        drive(1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk_ifid("rst_ack", NOP, 32'h0, 1'b0);

        rst = 1'b0;
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_fetch("rel", 1'b1, 32'h0);
        tick();
        chk_ifid("f0", 32'hA000_0000, 32'h4, 1'b1);
        chk_fetch("f0", 1'b1, 32'h4);

        drive(1'b1, 32'hA000_0004, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("f4", 32'hA000_0004, 32'h8, 1'b1);
        chk_fetch("f4", 1'b1, 32'h8);

        // Ack at PC=8 under freeze + stall: park in HOLD for three cycles.
        drive(1'b1, 32'hA000_0008, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("h1", 32'hA000_0004, 32'h8, 1'b1);
        chk_fetch("h1", 1'b0, 32'h8);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("h2", 32'hA000_0004, 32'h8, 1'b1);
        chk_fetch("h2", 1'b0, 32'h8);
        tick();
        chk_ifid("h3", 32'hA000_0004, 32'h8, 1'b1);
        chk_fetch("h3", 1'b0, 32'h8);

        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("hrel", 32'hA000_0008, 32'hC, 1'b1);
        chk_fetch("hrel", 1'b1, 32'hC);

        // No ack: bubble, Next_Address kept.
        tick();
        chk_ifid("bub", NOP, 32'hC, 1'b0);
        chk_fetch("bub", 1'b1, 32'hC);

        drive(1'b1, 32'hA000_000C, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("fc", 32'hA000_000C, 32'h10, 1'b1);
        drive(1'b1, 32'hA000_0010, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("f10", 32'hA000_0010, 32'h14, 1'b1);
        chk_fetch("f10", 1'b1, 32'h14);

        // Taken branch + flush at PC=20.
        drive(1'b1, 32'hA000_0014, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        tick();
        chk_ifid("br", NOP, 32'h14, 1'b0);
        chk_fetch("br", 1'b1, 32'h100);

        drive(1'b1, 32'hC000_0100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("f100", 32'hC000_0100, 32'h104, 1'b1);
        chk_fetch("f100", 1'b1, 32'h104);

        // Redirect while the request is outstanding; late ack must be dropped.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        tick();
        chk_ifid("pend1", NOP, 32'h104, 1'b0);
        chk_fetch("pend1", 1'b1, 32'h104);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_fetch("pend2", 1'b1, 32'h104);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("late", NOP, 32'h104, 1'b0);
        chk_fetch("late", 1'b1, 32'h40);

        drive(1'b1, 32'hE000_0040, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("f40", 32'hE000_0040, 32'h44, 1'b1);

        // Freeze holds IF/ID; flush overrides freeze.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("frz", 32'hE000_0040, 32'h44, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        chk_ifid("frzfl", NOP, 32'h44, 1'b0);

        // Stall-only ack parks in HOLD; branch from HOLD ignores PCWrite=0.
        drive(1'b1, 32'hF000_0044, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("st", NOP, 32'h44, 1'b0);
        chk_fetch("st", 1'b0, 32'h44);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        chk_ifid("hbr", NOP, 32'h44, 1'b0);
        chk_fetch("hbr", 1'b1, 32'hFFFF_FFFC);

        // PC wrap.
        drive(1'b1, 32'hF800_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("wrap", 32'hF800_0000, 32'h0, 1'b1);
        chk_fetch("wrap", 1'b1, 32'h0);
        drive(1'b1, 32'hFC00_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("f0b", 32'hFC00_0000, 32'h4, 1'b1);

        // Enter HOLD at PC=4, then reset mid-HOLD.
        drive(1'b1, 32'h9999_9999, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk_fetch("h4", 1'b0, 32'h4);
        rst = 1'b1;
        #1;
        chk_ifid("mrst", NOP, 32'h0, 1'b0);
        chk_fetch("mrst", 1'b0, 32'h0);
`ifdef FETCH_STAGE_PERF_EN
        check("mrst.pfetch", perf_fetch_cnt, 32'd0);
        check("mrst.pstall", perf_stall_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk_fetch("rel2", 1'b1, 32'h0);
        // A surviving hold buffer would be loaded here; expect a bubble instead.
        tick();
        chk_ifid("nobuf", NOP, 32'h0, 1'b0);
        drive(1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk_ifid("post", 32'h1111_1111, 32'h4, 1'b1);
`ifdef FETCH_STAGE_PERF_EN
        check("post.pfetch", perf_fetch_cnt, 32'd1);
        check("post.pstall", perf_stall_cnt, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
